ref_force_accumulator: RTL and testbench

- Sits directly downstream of the range-limited force evaluation unit.
- Consumes its per-pair stream: ref ID, neighbour ID, float32 force X/Y/Z and valid.
- Converts each force component to signed fixed point and accumulates the partial forces per reference particle.
- Emits one total-force record per reference particle, either when the ref ID changes or on an explicit flush from the pair-generation FSM.

---
 rtl/md_force_pkg.sv | 18 +
 rtl/fp32_to_fixed.sv | 57 +++++
 rtl/ref_force_accumulator.sv | 221 ++++++++++++++++++++++
 tb/tb_ref_force_accumulator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_force_pkg.sv
// Shared fixed-point force types and limits for the MD force pipeline.
package md_force_pkg;

  localparam int unsigned ACC_WIDTH_DEF = 48;
  localparam int unsigned FRAC_BITS_DEF = 24;

  typedef logic signed [ACC_WIDTH_DEF-1:0] fix_t;

  typedef struct packed {
    fix_t x;
    fix_t y;
    fix_t z;
  } force3_t;

  localparam fix_t FIX_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
  localparam fix_t FIX_MIN = {1'b1, {(ACC_WIDTH_DEF-2){1'b0}}, 1'b1};

endpackage

// File: rtl/fp32_to_fixed.sv
// Combinational float32 -> signed fixed-point conversion with symmetric clamp.
// Truncates toward zero; Inf/NaN/out-of-range clamp, NaN always clamps positive.
module fp32_to_fixed
  import md_force_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic        [31:0]          f_i,
  output logic signed [ACC_WIDTH-1:0] fix_c
);

  localparam int unsigned MW = 24;
  localparam logic signed [ACC_WIDTH-1:0] FMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] FMIN = {1'b1, {(ACC_WIDTH-2){1'b0}}, 1'b1};

  logic                 sign;
  logic [7:0]           expo;
  logic [MW-1:0]        sig;
  logic signed [11:0]   sh;
  logic [11:0]          lsh;
  logic [11:0]          rsh;
  logic [ACC_WIDTH-1:0] mag;
  logic                 clamp;
  logic                 nan;

  // Shift the 24-bit significand by (exp - 150 + FRAC_BITS) into the fixed-point grid.
  always_comb begin
    sign  = f_i[31];
    expo  = f_i[30:23];
    sig   = {1'b1, f_i[22:0]};
    sh    = $signed({4'b0000, expo}) - 12'sd150 + $signed(12'(FRAC_BITS));
    lsh   = sh;
    rsh   = 12'(-sh);
    mag   = '0;
    clamp = 1'b0;
    nan   = 1'b0;
    if (expo == 8'hFF) begin
      clamp = 1'b1;
      nan   = |f_i[22:0];
    end else if (expo == 8'h00) begin
      mag = '0;
    end else if (!sh[11]) begin
      if (lsh > 12'(ACC_WIDTH - MW - 1)) clamp = 1'b1;
      else                               mag   = ACC_WIDTH'(sig) << lsh;
    end else if (rsh >= 12'(MW)) begin
      mag = '0;
    end else begin
      mag = ACC_WIDTH'(sig >> rsh);
    end

    if (clamp)     fix_c = (sign && !nan) ? FMIN : FMAX;
    else if (sign) fix_c = -mag;
    else           fix_c = mag;
  end

endmodule

// File: rtl/ref_force_accumulator.sv
// Per-reference-particle force accumulator: converts float32 pair forces to
// fixed point and emits one total per reference. Option: REF_ACC_SAT_EN (saturating add).
module ref_force_accumulator
  import md_force_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic        [ID_WIDTH-1:0]  in_ref_id,
  input  logic        [DATA_WIDTH-1:0] in_force_x,
  input  logic        [DATA_WIDTH-1:0] in_force_y,
  input  logic        [DATA_WIDTH-1:0] in_force_z,
  input  logic                        in_flush,
  output logic                        out_valid,
  output logic        [ID_WIDTH-1:0]  out_ref_id,
  output logic signed [ACC_WIDTH-1:0] out_force_x,
  output logic signed [ACC_WIDTH-1:0] out_force_y,
  output logic signed [ACC_WIDTH-1:0] out_force_z,
  output logic        [CNT_WIDTH-1:0] out_count,
  output logic                        out_sat,
  output logic                        out_busy
);

  logic        [DATA_WIDTH-1:0] in_f   [3];
  logic signed [ACC_WIDTH-1:0]  conv_c [3];

  assign in_f[0] = in_force_x;
  assign in_f[1] = in_force_y;
  assign in_f[2] = in_force_z;

  for (genvar g = 0; g < 3; g++) begin : g_cvt
    fp32_to_fixed #(
      .ACC_WIDTH (ACC_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_cvt (
      .f_i   (in_f[g]),
      .fix_c (conv_c[g])
    );
  end

  // Stage 1: converted pair
  logic                        s1_valid_q;
  logic                        s1_flush_q;
  logic        [ID_WIDTH-1:0]  s1_id_q;
  logic signed [ACC_WIDTH-1:0] s1_val_q [3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_flush_q <= 1'b0;
      s1_id_q    <= '0;
      for (int i = 0; i < 3; i++) s1_val_q[i] <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_flush_q <= in_flush;
      s1_id_q    <= in_ref_id;
      for (int i = 0; i < 3; i++) s1_val_q[i] <= conv_c[i];
    end
  end

  // Stage 2: accumulator and output record
  logic signed [ACC_WIDTH-1:0] acc_q [3], acc_d [3];
  logic signed [ACC_WIDTH-1:0] sum_c [3];
  logic        [ID_WIDTH-1:0]  cur_id_q, cur_id_d;
  logic        [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic                        pend_q, pend_d;
  logic                        nonempty_q, nonempty_d;
  logic                        out_valid_q, out_valid_d;
  logic        [ID_WIDTH-1:0]  out_id_q, out_id_d;
  logic signed [ACC_WIDTH-1:0] out_f_q [3], out_f_d [3];
  logic        [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                        flush_eff_c;
  logic                        same_c;

`ifdef REF_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH:0] EXT_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] EXT_MIN = {2'b11, {(ACC_WIDTH-2){1'b0}}, 1'b1};

  logic signed [ACC_WIDTH:0] ext_c [3];
  logic                      sum_sat_c;
  logic                      sat_q, sat_d;

  // Saturating add: widen by one bit, compare against the symmetric limits.
  always_comb begin
    sum_sat_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ext_c[i] = {acc_q[i][ACC_WIDTH-1], acc_q[i]} + {s1_val_q[i][ACC_WIDTH-1], s1_val_q[i]};
      if (ext_c[i] > EXT_MAX) begin
        sum_c[i]  = EXT_MAX[ACC_WIDTH-1:0];
        sum_sat_c = 1'b1;
      end else if (ext_c[i] < EXT_MIN) begin
        sum_c[i]  = EXT_MIN[ACC_WIDTH-1:0];
        sum_sat_c = 1'b1;
      end else begin
        sum_c[i]  = ext_c[i][ACC_WIDTH-1:0];
      end
    end
    sat_d = sat_q | (sum_sat_c & s1_valid_q & same_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_q <= 1'b0;
    else      sat_q <= sat_d;
  end

  assign out_sat = sat_q;
`else
  always_comb begin
    for (int i = 0; i < 3; i++) sum_c[i] = acc_q[i] + s1_val_q[i];
  end

  assign out_sat = 1'b0;
`endif

  assign flush_eff_c = s1_flush_q | pend_q;
  assign same_c      = !nonempty_q || (s1_id_q == cur_id_q);
  assign cnt_inc_c   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    cur_id_d    = cur_id_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    nonempty_d  = nonempty_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    out_cnt_d   = out_cnt_q;
    for (int i = 0; i < 3; i++) begin
      acc_d[i]   = acc_q[i];
      out_f_d[i] = out_f_q[i];
    end

    if (s1_valid_q && same_c) begin
      cur_id_d = s1_id_q;
      if (flush_eff_c) begin
        out_valid_d = 1'b1;
        out_id_d    = s1_id_q;
        out_cnt_d   = cnt_inc_c;
        for (int i = 0; i < 3; i++) begin
          out_f_d[i] = sum_c[i];
          acc_d[i]   = '0;
        end
        cnt_d      = '0;
        nonempty_d = 1'b0;
        pend_d     = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) acc_d[i] = sum_c[i];
        cnt_d      = cnt_inc_c;
        nonempty_d = 1'b1;
      end
    end else if (s1_valid_q) begin
      // New reference while a sum is open: close the old one, start the new one.
      out_valid_d = 1'b1;
      out_id_d    = cur_id_q;
      out_cnt_d   = cnt_q;
      for (int i = 0; i < 3; i++) begin
        out_f_d[i] = acc_q[i];
        acc_d[i]   = s1_val_q[i];
      end
      cur_id_d   = s1_id_q;
      cnt_d      = CNT_WIDTH'(1);
      nonempty_d = 1'b1;
      pend_d     = flush_eff_c;
    end else if (flush_eff_c) begin
      if (nonempty_q) begin
        out_valid_d = 1'b1;
        out_id_d    = cur_id_q;
        out_cnt_d   = cnt_q;
        for (int i = 0; i < 3; i++) begin
          out_f_d[i] = acc_q[i];
          acc_d[i]   = '0;
        end
        cnt_d      = '0;
        nonempty_d = 1'b0;
      end
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_id_q    <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      nonempty_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_cnt_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]   <= '0;
        out_f_q[i] <= '0;
      end
    end else begin
      cur_id_q    <= cur_id_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      nonempty_q  <= nonempty_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_cnt_q   <= out_cnt_d;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]   <= acc_d[i];
        out_f_q[i] <= out_f_d[i];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ref_id  = out_id_q;
  assign out_force_x = out_f_q[0];
  assign out_force_y = out_f_q[1];
  assign out_force_z = out_f_q[2];
  assign out_count   = out_cnt_q;
  assign out_busy    = nonempty_q;

endmodule

// File: tb/tb_ref_force_accumulator.sv
// Scoreboard bench for ref_force_accumulator: directed pairs push expected
// records; a negedge monitor pops and compares whenever out_valid is seen.
module tb_ref_force_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_ref_id = '0;
  logic [31:0] in_force_x = '0, in_force_y = '0, in_force_z = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic [15:0] out_ref_id;
  logic [47:0] out_force_x, out_force_y, out_force_z;
  logic [7:0]  out_count;
  logic        out_sat;
  logic        out_busy;

  ref_force_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ref_id   (in_ref_id),
    .in_force_x  (in_force_x),
    .in_force_y  (in_force_y),
    .in_force_z  (in_force_z),
    .in_flush    (in_flush),
    .out_valid   (out_valid),
    .out_ref_id  (out_ref_id),
    .out_force_x (out_force_x),
    .out_force_y (out_force_y),
    .out_force_z (out_force_z),
    .out_count   (out_count),
    .out_sat     (out_sat),
    .out_busy    (out_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] id;
    logic [47:0] x, y, z;
    logic [7:0]  cnt;
    logic        sat;
    int          due;
  } rec_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } dchk_t;

  rec_t  exp_q[$];
  dchk_t dir_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  mon_en = 1'b0;

`ifdef REF_ACC_SAT_EN
  localparam logic SAT_EXP = 1'b1;
  localparam logic [47:0] OVF_X = 48'h7FFF_FFFF_FFFF;
`else
  localparam logic SAT_EXP = 1'b0;
  localparam logic [47:0] OVF_X = 48'hFFFF_FFFF_FFFE;
`endif

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: drains direct checks and scoreboards every emitted record.
  always @(negedge clk) begin
    dchk_t d;
    rec_t  e;
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      cmp(d.name, d.act, d.exp);
    end
    if (rst && mon_en && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: actual id %h required none", out_ref_id);
      end else begin
        e = exp_q.pop_front();
        cmp("rec_cycle", 64'(cyc), 64'(e.due));
        cmp("rec_id",    64'(out_ref_id),  64'(e.id));
        cmp("rec_x",     64'(out_force_x), 64'(e.x));
        cmp("rec_y",     64'(out_force_y), 64'(e.y));
        cmp("rec_z",     64'(out_force_z), 64'(e.z));
        cmp("rec_count", 64'(out_count),   64'(e.cnt));
        cmp("rec_sat",   64'(out_sat),     64'(e.sat));
      end
    end
  end

  task automatic dchk(input string name, input logic [63:0] act, input logic [63:0] exp);
    dchk_t d;
    d.name = name; d.act = act; d.exp = exp;
    dir_q.push_back(d);
  endtask

  task automatic drive(input logic v, input logic [15:0] id, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] z, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; in_ref_id = id; in_force_x = x; in_force_y = y; in_force_z = z; in_flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic expect_rec(input logic [15:0] id, input logic [47:0] x, input logic [47:0] y,
                            input logic [47:0] z, input logic [7:0] cnt, input logic sat,
                            input int lat);
    rec_t e;
    e.id = id; e.x = x; e.y = y; e.z = z; e.cnt = cnt; e.sat = sat; e.due = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    dchk({tag, "_valid"}, 64'(out_valid),   64'd0);
    dchk({tag, "_id"},    64'(out_ref_id),  64'd0);
    dchk({tag, "_x"},     64'(out_force_x), 64'd0);
    dchk({tag, "_y"},     64'(out_force_y), 64'd0);
    dchk({tag, "_z"},     64'(out_force_z), 64'd0);
    dchk({tag, "_count"}, 64'(out_count),   64'd0);
    dchk({tag, "_sat"},   64'(out_sat),     64'd0);
    dchk({tag, "_busy"},  64'(out_busy),    64'd0);
  endtask

  initial begin
    // Random traffic, then a 3-cycle reset
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 20; i++)
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(1, 3)), $urandom, $urandom,
            $urandom, 1'($urandom_range(0, 1)));
    @(negedge clk);
    rst = 1'b0;
    #1 check_zero("rst_async");
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk) check_zero("rst_hold");
    rst = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    repeat (4) idle();
    @(negedge clk) check_zero("rst_after");

    // Single reference with a separate flush
    drive(1'b1, 16'h0005, 32'h3F800000, 32'h3F800000, 32'h33C00000, 1'b0);
    drive(1'b1, 16'h0005, 32'h40000000, 32'h3F800000, 32'hB3C00000, 1'b0);
    drive(1'b1, 16'h0005, 32'hBF000000, 32'h3F800000, 32'h33C00000, 1'b0);
    drive(1'b0, 16'h0000, 32'h0,        32'h0,        32'h0,        1'b1);
    expect_rec(16'h0005, 48'h0000_0280_0000, 48'h0000_0300_0000, 48'h1, 8'd3, 1'b0, 2);
    @(negedge clk) dchk("busy_open", 64'(out_busy), 64'd1);
    repeat (3) idle();

    // ID change closes the previous reference
    drive(1'b1, 16'h0011, 32'h3F800000, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 16'h0011, 32'h3F800000, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 16'h0022, 32'h40400000, 32'hBF800000, 32'h0, 1'b0);
    expect_rec(16'h0011, 48'h0000_0200_0000, 48'h0, 48'h0, 8'd2, 1'b0, 2);
    idle();
    drive(1'b0, 16'h0000, 32'h0, 32'h0, 32'h0, 1'b1);
    expect_rec(16'h0022, 48'h0000_0300_0000, 48'hFFFF_FF00_0000, 48'h0, 8'd1, 1'b0, 2);
    repeat (3) idle();

    // New ID together with flush: two back-to-back records
    drive(1'b1, 16'h0101, 32'h3F800000, 32'h0, 32'h3F000000, 1'b0);
    drive(1'b1, 16'h0202, 32'h40000000, 32'h0, 32'h33000000, 1'b1);
    expect_rec(16'h0101, 48'h0000_0100_0000, 48'h0, 48'h0000_0080_0000, 8'd1, 1'b0, 2);
    expect_rec(16'h0202, 48'h0000_0200_0000, 48'h0, 48'h0, 8'd1, 1'b0, 3);
    repeat (4) idle();
    @(negedge clk) dchk("busy_after_pair", 64'(out_busy), 64'd0);

    // Flush on an empty accumulator emits nothing
    drive(1'b0, 16'h0000, 32'h0, 32'h0, 32'h0, 1'b1);
    repeat (4) idle();

    // Conversion clamps and accumulator overflow (flush on the last pair)
    drive(1'b1, 16'h0300, 32'h4B000000, 32'h7FC00000, 32'hFF800000, 1'b0);
    drive(1'b1, 16'h0300, 32'h4B000000, 32'h0,        32'h00000001, 1'b1);
    expect_rec(16'h0300, OVF_X, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0001, 8'd2, SAT_EXP, 2);
    repeat (4) idle();

    // Mid-operation reset with an open sum and a pair in stage 1
    drive(1'b1, 16'h0400, 32'h3F800000, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 16'h0400, 32'h3F800000, 32'h0, 32'h0, 1'b0);
    idle();
    dchk("busy_pre_rst", 64'(out_busy), 64'd1);
    #1 rst = 1'b0;
    #1 check_zero("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    drive(1'b0, 16'h0000, 32'h0, 32'h0, 32'h0, 1'b1);
    repeat (5) idle();
    @(negedge clk) check_zero("rst_mid_after");

    // Every expected record must have appeared
    repeat (3) @(negedge clk);
    dchk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end

endmodule
